// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Hazard / freeze controller beside the decode stage. It tracks the destination
// registers of the two instructions in flight (EX and MEM slots). From them it
// derives the bubble, flush and freeze controls for the IF, IF/ID and ID/EX
// stage registers.
//
// Handshakes:
//   id_valid qualifies every id_* field. With id_valid low the decode fields
//   are ignored and no stall can be raised.
//   mem_req / mem_ready is a request/completion pair. An access completes in
//   the cycle where both are high. mem_req high with mem_ready low freezes the
//   whole pipe in that same cycle. mem_ready without mem_req is ignored.
//
// Parameters:
//   FWD_EN       1: forwarding exists, so only a load in EX whose result is
//                needed by decode causes a stall.
//                0: any RAW against the EX or MEM slot causes a stall.
//   MEM_TIMEOUT  Number of WAIT cycles after which the sticky mem_err sets.
//
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   id_valid           decode holds a real instruction
//   id_src1, id_src2   source register indices (id_src2 used when id_two_src)
//   id_two_src         id_src2 is a true source
//   id_wb_en           decoded instruction writes back
//   id_mem_r_en        decoded instruction is a load
//   id_dest            decoded destination register
//   ex_branch_taken    branch resolved taken in EX this cycle
//   mem_req, mem_ready memory access request / completion
//   if_freeze          hold PC
//   if_id_freeze       hold IF/ID register
//   if_id_flush        clear IF/ID register
//   id_ex_flush        clear ID/EX register (inserts a bubble)
//   pipe_freeze        hold all stage registers during a memory wait
//   mem_err            sticky memory timeout flag, cleared only by rst
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
   parameter int unsigned FWD_EN      = 0,
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       id_valid,
   input  logic [3:0] id_src1,
   input  logic [3:0] id_src2,
   input  logic       id_two_src,
   input  logic       id_wb_en,
   input  logic       id_mem_r_en,
   input  logic [3:0] id_dest,
   input  logic       ex_branch_taken,
   input  logic       mem_req,
   input  logic       mem_ready,
   output logic       if_freeze,
   output logic       if_id_freeze,
   output logic       if_id_flush,
   output logic       id_ex_flush,
   output logic       pipe_freeze,
   output logic       mem_err
);

   localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

   typedef struct packed {
      logic       valid;
      logic       wb_en;
      logic       load;
      logic [3:0] dest;
   } slot_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   slot_t      ex_slot, mem_slot, ex_slot_nx;
   state_t     state, state_nx;
   logic [7:0] wait_cnt, wait_cnt_inc;
   logic       err_q;

   logic       match_ex, match_mem, raw;
   logic       mem_freeze, hazard_stall;

   // ---------------------------------------------------------------------------
   // Hazard detection
   // ---------------------------------------------------------------------------
   always_comb begin
      match_ex  = ex_slot.valid & ex_slot.wb_en &
                  ((ex_slot.dest == id_src1) |
                   (id_two_src & (ex_slot.dest == id_src2)));
      match_mem = mem_slot.valid & mem_slot.wb_en &
                  ((mem_slot.dest == id_src1) |
                   (id_two_src & (mem_slot.dest == id_src2)));
      if (FWD_EN != 0) begin
         // Forwarding covers everything except a load result not yet loaded.
         raw = match_ex & ex_slot.load;
      end else begin
         raw = match_ex | match_mem;
      end
      // A taken branch kills the decode instruction anyway, so no stall.
      hazard_stall = id_valid & raw & ~ex_branch_taken;
      mem_freeze   = mem_req & ~mem_ready;
   end

   // Next EX slot: the decode instruction if it advances, else a bubble.
   always_comb begin
      ex_slot_nx = '0;
      if (id_valid & ~hazard_stall & ~ex_branch_taken) begin
         ex_slot_nx.valid = 1'b1;
         ex_slot_nx.wb_en = id_wb_en;
         ex_slot_nx.load  = id_mem_r_en;
         ex_slot_nx.dest  = id_dest;
      end
   end

   // ---------------------------------------------------------------------------
   // Memory wait FSM: next state
   // ---------------------------------------------------------------------------
   always_comb begin
      state_nx     = state;
      wait_cnt_inc = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
      case (state)
         ST_IDLE: if (mem_req & ~mem_ready) state_nx = ST_WAIT;
         ST_WAIT: if (mem_ready)            state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // State: FSM, wait counter, sticky error, scoreboard
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         wait_cnt <= 8'd0;
         err_q    <= 1'b0;
         ex_slot  <= '0;
         mem_slot <= '0;
      end else begin
         state <= state_nx;
         if (state == ST_WAIT) begin
            wait_cnt <= wait_cnt_inc;
            // The counter and the flag reach the timeout in the same cycle.
            if (wait_cnt_inc == TIMEOUT) err_q <= 1'b1;
         end else begin
            wait_cnt <= 8'd0;
         end
         // The whole pipe holds during a memory wait, and so does the scoreboard.
         if (~mem_freeze) begin
            mem_slot <= ex_slot;
            ex_slot  <= ex_slot_nx;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs. These are gated by rst so that they drop at once on reset, even
   // while the memory inputs are still requesting.
   // ---------------------------------------------------------------------------
   always_comb begin
      pipe_freeze  = ~rst & mem_freeze;
      if_freeze    = ~rst & (hazard_stall | mem_freeze);
      if_id_freeze = ~rst & (hazard_stall | mem_freeze);
      // Flushes wait for the first unfrozen cycle; EX still holds the branch.
      if_id_flush  = ~rst & ex_branch_taken & ~mem_freeze;
      id_ex_flush  = ~rst & (ex_branch_taken | hazard_stall) & ~mem_freeze;
      mem_err      = ~rst & err_q;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Control block at the far end of the ID/EX stage-register interface. It generates the flush and freeze signals that the IF, IF/ID and ID/EX registers consume.
- Tracks in-flight destination registers in a two-slot scoreboard (EX, MEM) to detect RAW hazards.
- Inserts bubbles on hazards, flushes on taken branches and freezes the whole pipe during multi-cycle memory accesses.
- Sits beside the decode stage; takes inputs from ID, EX and the memory controller.

Parameters:
FWD_EN, 0, 1 = forwarding unit present; stall only on load-use against the EX slot. 0 = stall on any RAW against the EX or MEM slot.
MEM_TIMEOUT, 255, number of WAIT cycles after which sticky mem_err sets (8-bit counter).

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
id_valid  in  1  decode stage holds a real instruction
id_src1  in  4  Rn index
id_src2  in  4  Rm/Rd index (store data / register operand)
id_two_src  in  1  id_src2 is a true source
id_wb_en  in  1  decoded instruction writes back
id_mem_r_en  in  1  decoded instruction is a load
id_dest  in  4  decoded destination register
ex_branch_taken  in  1  branch resolved taken in EX this cycle
mem_req  in  1  MEM stage issuing an access this cycle
mem_ready  in  1  memory controller completion
if_freeze  out  1  hold PC
if_id_freeze  out  1  hold IF/ID register
if_id_flush  out  1  clear IF/ID register
id_ex_flush  out  1  clear ID/EX register (drives its flush input)
pipe_freeze  out  1  hold all stage registers (memory wait)
mem_err  out  1  sticky memory timeout flag

Behaviour:
- Reset: scoreboard slots invalid, FSM IDLE, wait counter 0, mem_err 0. All outputs 0 with all inputs low. Reset mid-WAIT aborts to IDLE immediately.
- Scoreboard slot fields: {valid, wb_en, load, dest[3:0]}.
- Match condition for a slot: valid & wb_en & (dest==id_src1 | (id_two_src & dest==id_src2)).
- raw, FWD_EN=0: match(EX) | match(MEM).
- raw, FWD_EN=1: match(EX) & EX.load.
- hazard_stall = id_valid & raw & ~ex_branch_taken. A taken branch has priority over a hazard.
- Memory FSM, states IDLE and WAIT:
  - IDLE -> WAIT when mem_req & ~mem_ready.
  - WAIT -> IDLE when mem_ready.
  - mem_freeze = mem_req & ~mem_ready (combinational, same cycle).
  - Counter clears in IDLE and increments each WAIT cycle, saturating.
  - When counter == MEM_TIMEOUT, mem_err sets and stays set until rst. Freeze persists until mem_ready.
- Outputs are combinational from state and inputs, zero latency:
  - pipe_freeze = mem_freeze
  - if_freeze = if_id_freeze = hazard_stall | mem_freeze
  - if_id_flush = ex_branch_taken & ~mem_freeze
  - id_ex_flush = (ex_branch_taken | hazard_stall) & ~mem_freeze
- Flushes are suppressed while frozen. EX holds the branch, so ex_branch_taken reasserts on the first unfrozen cycle.
- Scoreboard update, only on clk edges with ~mem_freeze:
  - MEM slot <= EX slot.
  - EX slot <= {1, id_wb_en, id_mem_r_en, id_dest} if id_valid & ~hazard_stall & ~ex_branch_taken; otherwise all zero (bubble).
- Scoreboard holds unchanged while mem_freeze is asserted.
- mem_ready without mem_req: ignored.
- Simultaneous hazard and mem_freeze: only the freeze signals assert; the hazard is re-evaluated after release.

Test Plan:
- Reset, then FWD_EN=0: issue ADD dest=R3; next cycle SUB src1=R3 -> if_freeze=if_id_freeze=id_ex_flush=1 for exactly 2 cycles, released on the 3rd.
- FWD_EN=1: LDR dest=R5 followed by ADD src2=R5, two_src=1 -> one stall cycle. Repeat with non-load dest=R5 -> zero stall cycles.
- Taken branch while ID holds a hazard on R2 -> if_id_flush=id_ex_flush=1, freezes 0; EX slot becomes invalid next cycle.
- mem_req=1 with mem_ready low for 4 cycles -> pipe_freeze=1 for those 4 cycles; scoreboard unchanged; no flush even with ex_branch_taken=1 inside the window.
- MEM_TIMEOUT=8, mem_ready held low 10 cycles -> mem_err rises after the 8th WAIT cycle and stays 1 after mem_ready; only rst clears it.
- Assert rst mid-WAIT with a hazard pending -> all outputs 0 asynchronously; FSM IDLE and scoreboard empty on release.
